fft_cfg_driver: RTL and testbench

- Parameterised AXI4-Stream master for the FFT/IFFT core configuration channel.
- Sends a default configuration automatically after reset, then accepts runtime reconfiguration requests: transform length, CP length, per-channel direction and scaling schedule.
- Sits between the system control logic (transmitter IFFT / receiver FFT setup) and the FFT core s_axis_config port.
- Holds tvalid until tready, as AXI requires, and reports completion, dropped requests and handshake timeout.

---
 rtl/fft_cfg_pkg.sv | 49 ++++
 rtl/fft_cfg_pack.sv | 30 +++
 rtl/fft_cfg_driver.sv | 180 ++++++++++++++++++
 tb/tb_fft_cfg_driver.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cfg_pkg.sv
// fft_cfg_pkg: shared state type and config-word packing
// helpers for the FFT configuration-channel driver.
package fft_cfg_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SEND = 2'd1,
        ST_IDLE = 2'd2
    } cfg_state_t;

    localparam int PACK_MAX_W = 512;

    typedef logic [PACK_MAX_W-1:0] pack_word_t;

    function automatic int ceil8(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

    function automatic int cfg_tdata_w(
        input int nfft_w,
        input int cp_w,
        input int num_ch,
        input int scale_w
    );
        return ceil8(nfft_w) + ceil8(cp_w)
             + ceil8(num_ch * (1 + scale_w));
    endfunction

    // Fields arrive zero-extended; each lands on its byte-aligned offset.
    function automatic pack_word_t pack_cfg(
        input pack_word_t nfft,
        input pack_word_t cp,
        input pack_word_t fwd_inv,
        input pack_word_t scale,
        input int         nfft_w,
        input int         cp_w,
        input int         num_ch
    );
        int cp_off;
        int dir_off;
        cp_off  = ceil8(nfft_w);
        dir_off = cp_off + ceil8(cp_w);
        return nfft
             | (cp << cp_off)
             | (fwd_inv << dir_off)
             | (scale << (dir_off + num_ch));
    endfunction

endpackage

// File: rtl/fft_cfg_pack.sv
// fft_cfg_pack: combinational packer turning config fields
// into the FFT core s_axis_config word.
module fft_cfg_pack
    import fft_cfg_pkg::*;
#(
    parameter int NUM_CH  = 1,
    parameter int NFFT_W  = 5,
    parameter int CP_W    = 7,
    parameter int SCALE_W = 8,
    localparam int TDATA_W =
        cfg_tdata_w(NFFT_W, CP_W, NUM_CH, SCALE_W)
) (
    input  logic [NFFT_W-1:0]         nfft,
    input  logic [CP_W-1:0]           cp,
    input  logic [NUM_CH-1:0]         fwd_inv,
    input  logic [NUM_CH*SCALE_W-1:0] scale,
    output logic [TDATA_W-1:0]        tdata
);

    assign tdata = TDATA_W'(pack_cfg(
        pack_word_t'(nfft),
        pack_word_t'(cp),
        pack_word_t'(fwd_inv),
        pack_word_t'(scale),
        NFFT_W,
        CP_W,
        NUM_CH
    ));

endmodule

// File: rtl/fft_cfg_driver.sv
// fft_cfg_driver: AXI4-Stream master for the FFT core config
// channel; sends defaults after reset, then runtime requests.
module fft_cfg_driver
    import fft_cfg_pkg::*;
#(
    parameter int NUM_CH      = 1,
    parameter int NFFT_W      = 5,
    parameter int NFFT_MIN    = 3,
    parameter int NFFT_MAX    = 6,
    parameter int CP_W        = 7,
    parameter int SCALE_W     = 8,
    parameter int DEF_NFFT    = 6,
    parameter int DEF_CP      = 16,
    parameter bit DEF_FWD_INV = 1'b0,
    parameter logic [SCALE_W-1:0] DEF_SCALE = 8'b01101010,
    parameter int TIMEOUT_CYC = 1024,
    localparam int TDATA_W =
        cfg_tdata_w(NFFT_W, CP_W, NUM_CH, SCALE_W)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      cfg_req,
    input  logic [NFFT_W-1:0]         cfg_nfft,
    input  logic [CP_W-1:0]           cfg_cp,
    input  logic [NUM_CH-1:0]         cfg_fwd_inv,
    input  logic [NUM_CH*SCALE_W-1:0] cfg_scale,
    input  logic                      m_axis_config_tready,
    output logic [TDATA_W-1:0]        m_axis_config_tdata,
    output logic                      m_axis_config_tvalid,
    output logic                      cfg_busy,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic                      cfg_drop,
    output logic                      cfg_timeout,
    output logic [15:0]               cfg_count
);

    localparam int WCW =
        (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WCW-1:0] WAIT_LAST =
        WCW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    cfg_state_t state;

    logic [NFFT_W-1:0]         sh_nfft;
    logic [CP_W-1:0]           sh_cp;
    logic [NUM_CH-1:0]         sh_fwd;
    logic [NUM_CH*SCALE_W-1:0] sh_scale;

    logic [NFFT_W-1:0]         nx_nfft;
    logic [CP_W-1:0]           nx_cp;
    logic [NUM_CH-1:0]         nx_fwd;
    logic [NUM_CH*SCALE_W-1:0] nx_scale;
    logic [TDATA_W-1:0]        nx_tdata;

    logic [WCW-1:0] wait_cnt;
    logic           to_fired;
    logic           nfft_ok;
    logic           accept;
    logic           hshake;

    assign nfft_ok = (cfg_nfft >= NFFT_W'(NFFT_MIN))
                  && (cfg_nfft <= NFFT_W'(NFFT_MAX));
    assign accept  = (state == ST_IDLE) && cfg_req && nfft_ok;
    assign hshake  = m_axis_config_tvalid && m_axis_config_tready;

    // Next shadow contents: defaults in LOAD, request fields on accept.
    always_comb begin
        nx_nfft  = sh_nfft;
        nx_cp    = sh_cp;
        nx_fwd   = sh_fwd;
        nx_scale = sh_scale;
        if (state == ST_LOAD) begin
            nx_nfft  = NFFT_W'(DEF_NFFT);
            nx_cp    = CP_W'(DEF_CP);
            nx_fwd   = {NUM_CH{DEF_FWD_INV}};
            nx_scale = {NUM_CH{DEF_SCALE}};
        end else if (accept) begin
            nx_nfft  = cfg_nfft;
            nx_cp    = cfg_cp;
            nx_fwd   = cfg_fwd_inv;
            nx_scale = cfg_scale;
        end
    end

    fft_cfg_pack #(
        .NUM_CH  (NUM_CH),
        .NFFT_W  (NFFT_W),
        .CP_W    (CP_W),
        .SCALE_W (SCALE_W)
    ) u_pack (
        .nfft    (nx_nfft),
        .cp      (nx_cp),
        .fwd_inv (nx_fwd),
        .scale   (nx_scale),
        .tdata   (nx_tdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state                <= ST_LOAD;
            sh_nfft              <= '0;
            sh_cp                <= '0;
            sh_fwd               <= '0;
            sh_scale             <= '0;
            m_axis_config_tvalid <= 1'b0;
            m_axis_config_tdata  <= '0;
            cfg_busy             <= 1'b1;
            cfg_done             <= 1'b0;
            cfg_err              <= 1'b0;
            cfg_drop             <= 1'b0;
            cfg_timeout          <= 1'b0;
            cfg_count            <= 16'd0;
            wait_cnt             <= '0;
            to_fired             <= 1'b0;
        end else begin
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_drop    <= 1'b0;
            cfg_timeout <= 1'b0;
            case (state)
                ST_LOAD: begin
                    sh_nfft              <= nx_nfft;
                    sh_cp                <= nx_cp;
                    sh_fwd               <= nx_fwd;
                    sh_scale             <= nx_scale;
                    m_axis_config_tvalid <= 1'b1;
                    m_axis_config_tdata  <= nx_tdata;
                    cfg_busy             <= 1'b1;
                    cfg_drop             <= cfg_req;
                    wait_cnt             <= '0;
                    to_fired             <= 1'b0;
                    state                <= ST_SEND;
                end
                ST_SEND: begin
                    cfg_drop <= cfg_req;
                    if (hshake) begin
                        m_axis_config_tvalid <= 1'b0;
                        m_axis_config_tdata  <= '0;
                        cfg_busy             <= 1'b0;
                        cfg_done             <= 1'b1;
                        cfg_count            <= cfg_count + 16'd1;
                        state                <= ST_IDLE;
                    end else if (TIMEOUT_CYC != 0 && !to_fired) begin
                        // tvalid is held; only the flag fires, once.
                        if (wait_cnt == WAIT_LAST) begin
                            cfg_timeout <= 1'b1;
                            to_fired    <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        sh_nfft              <= nx_nfft;
                        sh_cp                <= nx_cp;
                        sh_fwd               <= nx_fwd;
                        sh_scale             <= nx_scale;
                        m_axis_config_tvalid <= 1'b1;
                        m_axis_config_tdata  <= nx_tdata;
                        cfg_busy             <= 1'b1;
                        wait_cnt             <= '0;
                        to_fired             <= 1'b0;
                        state                <= ST_SEND;
                    end else begin
                        cfg_err <= cfg_req;
                    end
                end
                default: begin
                    m_axis_config_tvalid <= 1'b0;
                    m_axis_config_tdata  <= '0;
                    cfg_busy             <= 1'b1;
                    state                <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_cfg_driver.sv
// tb_fft_cfg_driver: default and two-channel drivers against a
// transaction-level reference model with random stimulus.
module tb_fft_cfg_driver;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // DUT A: default parameters
    logic        rst_a, req_a, rdy_a;
    logic [4:0]  nfft_a;
    logic [6:0]  cp_a;
    logic [0:0]  fwd_a;
    logic [7:0]  scale_a;
    logic [31:0] tdata_a;
    logic        tvalid_a, busy_a, done_a, err_a, drop_a, to_a;
    logic [15:0] cnt_a;

    // DUT B: two channels, short timeout
    logic        rst_b, req_b, rdy_b;
    logic [4:0]  nfft_b;
    logic [6:0]  cp_b;
    logic [1:0]  fwd_b;
    logic [15:0] scale_b;
    logic [39:0] tdata_b;
    logic        tvalid_b, busy_b, done_b, err_b, drop_b, to_b;
    logic [15:0] cnt_b;

    logic [4:0]  p_nfft;
    logic [6:0]  p_cp;
    logic [1:0]  p_fwd;
    logic [15:0] p_scale;
    logic [39:0] p_tdata;

    fft_cfg_driver u_dut_a (
        .CLK                  (CLK),
        .RST                  (rst_a),
        .cfg_req              (req_a),
        .cfg_nfft             (nfft_a),
        .cfg_cp               (cp_a),
        .cfg_fwd_inv          (fwd_a),
        .cfg_scale            (scale_a),
        .m_axis_config_tready (rdy_a),
        .m_axis_config_tdata  (tdata_a),
        .m_axis_config_tvalid (tvalid_a),
        .cfg_busy             (busy_a),
        .cfg_done             (done_a),
        .cfg_err              (err_a),
        .cfg_drop             (drop_a),
        .cfg_timeout          (to_a),
        .cfg_count            (cnt_a)
    );

    fft_cfg_driver #(
        .NUM_CH      (2),
        .TIMEOUT_CYC (8)
    ) u_dut_b (
        .CLK                  (CLK),
        .RST                  (rst_b),
        .cfg_req              (req_b),
        .cfg_nfft             (nfft_b),
        .cfg_cp               (cp_b),
        .cfg_fwd_inv          (fwd_b),
        .cfg_scale            (scale_b),
        .m_axis_config_tready (rdy_b),
        .m_axis_config_tdata  (tdata_b),
        .m_axis_config_tvalid (tvalid_b),
        .cfg_busy             (busy_b),
        .cfg_done             (done_b),
        .cfg_err              (err_b),
        .cfg_drop             (drop_b),
        .cfg_timeout          (to_b),
        .cfg_count            (cnt_b)
    );

    fft_cfg_pack #(
        .NUM_CH (2)
    ) u_pack (
        .nfft    (p_nfft),
        .cp      (p_cp),
        .fwd_inv (p_fwd),
        .scale   (p_scale),
        .tdata   (p_tdata)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: nfft byte, cp byte, then dir bits and schedules.
    int nch[2] = '{1, 2};
    int tmo[2] = '{1024, 8};

    bit          m_load[2];
    bit          m_offer[2];
    logic [63:0] m_word[2];
    int          m_wait[2];
    logic [15:0] m_cnt[2];
    bit          m_done[2], m_err[2], m_drop[2], m_to[2];

    function automatic logic [63:0] ref_word(input int n,
        input logic [63:0] nfft, input logic [63:0] cp,
        input logic [63:0] fwd, input logic [63:0] scale);
        return nfft + cp * 64'd256 + fwd * 64'd65536
             + scale * (64'd65536 << n);
    endfunction

    function automatic logic [63:0] def_word(input int d);
        return ref_word(nch[d], 64'd6, 64'd16, 64'd0,
                        (nch[d] == 2) ? 64'h6A6A : 64'h6A);
    endfunction

    task automatic model_step(input int d, input bit rst,
        input bit req, input logic [63:0] nfft,
        input logic [63:0] cp, input logic [63:0] fwd,
        input logic [63:0] scale, input bit rdy);
        m_done[d] = 0;
        m_err[d]  = 0;
        m_drop[d] = 0;
        m_to[d]   = 0;
        if (rst) begin
            m_load[d]  = 1;
            m_offer[d] = 0;
            m_cnt[d]   = 0;
        end else if (m_load[d]) begin
            m_load[d]  = 0;
            m_offer[d] = 1;
            m_word[d]  = def_word(d);
            m_wait[d]  = 0;
            m_drop[d]  = req;
        end else if (m_offer[d]) begin
            m_drop[d] = req;
            if (rdy) begin
                m_offer[d] = 0;
                m_done[d]  = 1;
                m_cnt[d]   = m_cnt[d] + 16'd1;
            end else begin
                m_wait[d]++;
                if (tmo[d] != 0 && m_wait[d] == tmo[d]) m_to[d] = 1;
            end
        end else if (req) begin
            if (nfft >= 3 && nfft <= 6) begin
                m_offer[d] = 1;
                m_word[d]  = ref_word(nch[d], nfft, cp, fwd, scale);
                m_wait[d]  = 0;
            end else begin
                m_err[d] = 1;
            end
        end
    endtask

    task automatic compare(input int d, input logic [63:0] tdata,
        input bit tvalid, input bit busy, input bit done,
        input bit err, input bit drop, input bit to,
        input logic [15:0] cnt);
        string p;
        p = (d == 0) ? "A" : "B";
        chk({p, ".tvalid"}, 64'(tvalid), 64'(m_offer[d]));
        chk({p, ".tdata"}, tdata, m_offer[d] ? m_word[d] : 64'd0);
        chk({p, ".flags"}, 64'({busy, done, err, drop, to}),
            64'({m_load[d] | m_offer[d], m_done[d], m_err[d],
                 m_drop[d], m_to[d]}));
        chk({p, ".count"}, 64'(cnt), 64'(m_cnt[d]));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step(0, rst_a, req_a, 64'(nfft_a), 64'(cp_a),
                   64'(fwd_a), 64'(scale_a), rdy_a);
        model_step(1, rst_b, req_b, 64'(nfft_b), 64'(cp_b),
                   64'(fwd_b), 64'(scale_b), rdy_b);
        @(negedge CLK);
        compare(0, 64'(tdata_a), tvalid_a, busy_a, done_a, err_a,
                drop_a, to_a, cnt_a);
        compare(1, 64'(tdata_b), tvalid_b, busy_b, done_b, err_b,
                drop_b, to_b, cnt_b);
    endtask

    initial begin
        int n_tv;
        int to_at;
        int to_n;
        bit to_seen;

        for (int d = 0; d < 2; d++) begin
            m_load[d]  = 1;
            m_offer[d] = 0;
            m_word[d]  = 0;
            m_wait[d]  = 0;
            m_cnt[d]   = 0;
        end
        rst_a = 1; req_a = 0; rdy_a = 1;
        nfft_a = 0; cp_a = 0; fwd_a = 0; scale_a = 0;
        rst_b = 1; req_b = 0; rdy_b = 0;
        nfft_b = 0; cp_b = 0; fwd_b = 0; scale_b = 0;
        p_nfft = 0; p_cp = 0; p_fwd = 0; p_scale = 0;

        repeat (3) cycle();
        chk("A.rst_busy", 64'(busy_a), 64'd1);
        chk("A.rst_tvalid", 64'(tvalid_a), 64'd0);
        chk("A.rst_count", 64'(cnt_a), 64'd0);

        // Defaults after reset, tready high
        rst_a = 0;
        cycle();
        chk("A.def_valid", 64'(tvalid_a), 64'd1);
        chk("A.def_word", 64'(tdata_a), 64'h00D41006);
        cycle();
        chk("A.def_done", 64'(done_a), 64'd1);
        chk("A.def_count", 64'(cnt_a), 64'd1);
        chk("A.def_idle", 64'(busy_a), 64'd0);

        // Defaults with a 50-cycle stall
        rst_a = 1; rdy_a = 0;
        cycle();
        rst_a = 0;
        cycle();
        to_seen = 0;
        repeat (50) begin
            cycle();
            to_seen |= to_a;
        end
        rdy_a = 1;
        cycle();
        chk("A.stall_count", 64'(cnt_a), 64'd1);
        chk("A.stall_no_to", 64'(to_seen), 64'd0);

        // Runtime request, then a request while sending
        rdy_a = 0; req_a = 1;
        nfft_a = 5; cp_a = 8; fwd_a = 1; scale_a = 8'hAA;
        cycle();
        req_a = 0;
        chk("A.req_word", 64'(tdata_a), 64'h01550805);
        req_a = 1; nfft_a = 3; cp_a = 1; scale_a = 8'h11;
        cycle();
        req_a = 0;
        chk("A.drop", 64'(drop_a), 64'd1);
        chk("A.word_kept", 64'(tdata_a), 64'h01550805);
        rdy_a = 1;
        cycle();
        chk("A.req_count", 64'(cnt_a), 64'd2);
        cycle();

        // Out-of-range lengths
        req_a = 1; nfft_a = 7;
        cycle();
        chk("A.err_hi", 64'(err_a), 64'd1);
        chk("A.err_novalid", 64'(tvalid_a), 64'd0);
        nfft_a = 2;
        cycle();
        chk("A.err_lo", 64'(err_a), 64'd1);
        nfft_a = 3;
        cycle();
        req_a = 0;
        cycle();
        chk("A.min_count", 64'(cnt_a), 64'd3);

        // Timeout on the two-channel driver
        rst_b = 0;
        cycle();
        n_tv = 0; to_at = -1; to_n = 0;
        repeat (20) begin
            if (to_b) begin
                to_n++;
                if (to_at < 0) to_at = n_tv;
            end
            if (tvalid_b) n_tv++;
            cycle();
        end
        chk("B.to_pos", 64'(to_at), 64'd8);
        chk("B.to_once", 64'(to_n), 64'd1);
        chk("B.to_held", 64'(tvalid_b), 64'd1);
        rdy_b = 1;
        cycle();
        chk("B.to_done", 64'(done_b), 64'd1);
        rdy_b = 0;

        // Two-channel word, then reset mid-send
        req_b = 1; nfft_b = 4; cp_b = 7'h55;
        fwd_b = 2'b10; scale_b = 16'hC3A5;
        cycle();
        req_b = 0;
        chk("B.word2ch", 64'(tdata_b), 64'h030E965504);
        rst_b = 1;
        cycle();
        chk("B.rst_drop", 64'(tvalid_b), 64'd0);
        rst_b = 0; rdy_b = 1;
        cycle();
        chk("B.def_word", 64'(tdata_b), 64'h01A9A81006);
        cycle();
        chk("B.def_count", 64'(cnt_b), 64'd1);

        // Packer against the arithmetic model
        repeat (8) begin
            p_nfft  = 5'($urandom);
            p_cp    = 7'($urandom);
            p_fwd   = 2'($urandom);
            p_scale = 16'($urandom);
            #1;
            chk("P.word", 64'(p_tdata),
                ref_word(2, 64'(p_nfft), 64'(p_cp),
                         64'(p_fwd), 64'(p_scale)));
        end

        // Random traffic on both drivers
        repeat (600) begin
            rst_a   = ($urandom_range(0, 99) == 0);
            req_a   = ($urandom_range(0, 3) == 0);
            nfft_a  = 5'($urandom_range(1, 8));
            cp_a    = 7'($urandom);
            fwd_a   = 1'($urandom);
            scale_a = 8'($urandom);
            rdy_a   = ($urandom_range(0, 2) != 0);
            rst_b   = ($urandom_range(0, 99) == 0);
            req_b   = ($urandom_range(0, 3) == 0);
            nfft_b  = 5'($urandom_range(1, 8));
            cp_b    = 7'($urandom);
            fwd_b   = 2'($urandom);
            scale_b = 16'($urandom);
            rdy_b   = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
